cnt_step_rpt: RTL and testbench
===============================

Name: cnt_step_rpt

Overview:
- Parametrised successor of the panel up/down counter used by the serdes front-panel settings.
- Adds programmable lower/upper bounds, and a choice of saturate or wrap at the bounds.
- Adds auto-repeat: a held command steps once, then repeats after a hold delay at a fixed period.
- Sits between the debounced button/command logic and the settings registers; CNT drives those registers directly.

Parameters:
W, 8, counter and bound width
STEP_S, 1, small step magnitude
STEP_L, 10, large step magnitude
DLY_W, 16, width of HOLD_DLY / REP_PER timers

Ports:
CLK  in  1  clock
RSTX  in  1  reset, asynchronous, active-low
CLR  in  1  sync clear: CNT<=LBND, FSM->IDLE
LBND  in  W  lower bound (inclusive)
UBND  in  W  upper bound (inclusive)
MODE_WRAP  in  1  0=saturate at bounds, 1=wrap to opposite bound
HOLD_DLY  in  DLY_W  cycles from first step to first repeat; 0 disables repeat
REP_PER  in  DLY_W  cycles between repeats; 0 treated as 1
INC_S, INC_L, DEC_S, DEC_L  in  1 each  level commands (held = button held)
CNT  out  W  counter value
AT_LBND  out  1  comb, CNT==LBND
AT_UBND  out  1  comb, CNT==UBND
CHG  out  1  registered pulse: CNT changed at this edge
SAT  out  1  registered pulse: a step was clamped (saturate) or wrapped

Behaviour:
- Reset (RSTX low, async): CNT=0, CHG=0, SAT=0, FSM=IDLE, timer=0. Reset mid-hold aborts the repeat; re-arming needs the command again after reset release.
- Priority at every edge: CLR > bound-fix > command.
- Command select: INC_S > INC_L > DEC_S > DEC_L. Only the winning command is the "active command" (cmd).
- FSM states: IDLE, HOLD, REPEAT.
- IDLE: at the first edge k where cmd != none, apply the step at edge k (CNT visible after k). Go to HOLD with timer=0.
- HOLD:
  - cmd released -> IDLE, no step.
  - cmd differs from the latched cmd -> step immediately, re-latch, timer=0, stay in HOLD.
  - Timer reaches HOLD_DLY (edge k+HOLD_DLY) -> step, go to REPEAT, timer=0.
  - HOLD_DLY=0 -> stay in HOLD without repeating.
- REPEAT: step at every edge k+HOLD_DLY+n*REP_PER. Release returns to IDLE; a cmd change behaves as in HOLD (step, go to HOLD).
- Arithmetic: W+2-bit signed intermediate, sum = CNT +/- STEP. Result above UBND or below LBND is out of range.
  - Saturate mode: clamp to the crossed bound, SAT=1.
  - Wrap mode: load the opposite bound (no modular carry), SAT=1.
  - Exactly hitting a bound is not SAT.
- Bound-fix: if CNT>UBND or CNT<LBND (bounds changed by software), force CNT to the nearer violated bound at the next edge. That edge's command step is discarded; the FSM still advances.
- Misconfig LBND>UBND: CNT forced to LBND, commands ignored, FSM held in IDLE.
- CHG=1 at any edge where CNT's new value != old value (step, CLR, bound-fix). SAT only on command steps.
- Step at a bound in saturate mode (e.g. INC_S at UBND): CNT unchanged, CHG=0, SAT=1.

Decomposition:
- Shared package/include holds:
  - FSM state encodings (IDLE/HOLD/REPEAT).
  - Command encodings (NONE, INC_S, INC_L, DEC_S, DEC_L).
- Sub-module rpt_timer is natural. It contains the FSM, the latched cmd, and the DLY_W timer. Outputs: step strobe and the selected cmd.
- Top level cnt_step_rpt keeps the bound arithmetic, CLR, bound-fix, and the CHG/SAT flags.

Test Plan:
1. Reset/CLR: reset -> CNT=0, AT_LBND=0 with LBND=5. Then CLR 1 cycle -> CNT=5, CHG=1 pulse, AT_LBND=1.
2. Saturate: LBND=0, UBND=99, CNT=95, INC_L 1 cycle -> CNT=99, SAT=1, AT_UBND=1. INC_S again -> CNT=99, CHG=0, SAT=1.
3. Wrap: MODE_WRAP=1, LBND=0, UBND=59, CNT=2, DEC_L 1 cycle -> CNT=59, SAT=1. Then INC_S -> CNT=0, SAT=1.
4. Auto-repeat: HOLD_DLY=4, REP_PER=2, CNT=0, INC_S held for edges k..k+11. Steps at k, k+4, k+6, k+8, k+10 -> final CNT=5, five CHG pulses.
5. Command switch: INC_S held 2 edges, then DEC_L held from CNT=30 with HOLD_DLY=8. Immediate step gives CNT=21 (30+1-10) at the switch edge; next repeat fires 8 edges later.
6. Bound change/misconfig: CNT=50, UBND changed to 30 -> next edge CNT=30, CHG=1, SAT=0. Then LBND=40, UBND=30 -> CNT=40, INC_S ignored.

Source files
------------

// File: rtl/cnt_step_rpt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_step_rpt_pkg : shared FSM/command encodings for the stepping counter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cnt_step_rpt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_INC_S = 3'd1,
    CMD_INC_L = 3'd2,
    CMD_DEC_S = 3'd3,
    CMD_DEC_L = 3'd4
  } cmd_e;

  // Fixed priority among simultaneously held buttons
  function automatic cmd_e cmd_select(input logic inc_s, input logic inc_l,
                                      input logic dec_s, input logic dec_l);
    if (inc_s)      return CMD_INC_S;
    else if (inc_l) return CMD_INC_L;
    else if (dec_s) return CMD_DEC_S;
    else if (dec_l) return CMD_DEC_L;
    else            return CMD_NONE;
  endfunction

  function automatic logic cmd_is_inc(input cmd_e c);
    return (c == CMD_INC_S) || (c == CMD_INC_L);
  endfunction

  function automatic logic cmd_is_small(input cmd_e c);
    return (c == CMD_INC_S) || (c == CMD_DEC_S);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_step_rpt_if.sv
// ---------------------------------------------------------------------------
// cnt_step_rpt_if : control/status bundle between command logic and counter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cnt_step_rpt_if #(
  parameter int W     = 8,
  parameter int DLY_W = 16
);
  import cnt_step_rpt_pkg::*;

  logic             clr;
  logic [W-1:0]     lbnd;
  logic [W-1:0]     ubnd;
  logic             mode_wrap;
  logic [DLY_W-1:0] hold_dly;
  logic [DLY_W-1:0] rep_per;
  logic             inc_s;
  logic             inc_l;
  logic             dec_s;
  logic             dec_l;
  logic [W-1:0]     cnt;
  logic             at_lbnd;
  logic             at_ubnd;
  logic             chg;
  logic             sat;

  modport master (
    output clr, lbnd, ubnd, mode_wrap, hold_dly, rep_per,
    output inc_s, inc_l, dec_s, dec_l,
    input  cnt, at_lbnd, at_ubnd, chg, sat
  );

  modport slave (
    input  clr, lbnd, ubnd, mode_wrap, hold_dly, rep_per,
    input  inc_s, inc_l, dec_s, dec_l,
    output cnt, at_lbnd, at_ubnd, chg, sat
  );

endinterface

`default_nettype wire

// File: rtl/cnt_step_rpt_timer.sv
// ---------------------------------------------------------------------------
// cnt_step_rpt_timer : command select, hold/repeat FSM and delay timer
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cnt_step_rpt_timer
  import cnt_step_rpt_pkg::*;
#(
  parameter int DLY_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             hold_idle_i,
  input  wire logic             inc_s_i,
  input  wire logic             inc_l_i,
  input  wire logic             dec_s_i,
  input  wire logic             dec_l_i,
  input  wire logic [DLY_W-1:0] hold_dly_i,
  input  wire logic [DLY_W-1:0] rep_per_i,
  output logic                  step_o,
  output cmd_e                  cmd_o
);

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [DLY_W-1:0] tmr_q, tmr_d;
  logic [DLY_W:0]   w_tmr_inc;
  logic [DLY_W-1:0] w_rep_eff;
  cmd_e             w_cmd;

  assign w_cmd     = cmd_select(inc_s_i, inc_l_i, dec_s_i, dec_l_i);
  assign cmd_o     = w_cmd;
  // One extra bit so the compare never aliases on timer rollover
  assign w_tmr_inc = {1'b0, tmr_q} + {{DLY_W{1'b0}}, 1'b1};
  assign w_rep_eff = (rep_per_i == '0) ? {{(DLY_W-1){1'b0}}, 1'b1} : rep_per_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    tmr_d   = tmr_q;
    step_o  = 1'b0;
    if (hold_idle_i) begin
      state_d = ST_IDLE;
      cmd_d   = CMD_NONE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_cmd != CMD_NONE) begin
            step_o  = 1'b1;
            cmd_d   = w_cmd;
            tmr_d   = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (w_cmd == CMD_NONE) begin
            state_d = ST_IDLE;
            cmd_d   = CMD_NONE;
            tmr_d   = '0;
          end else if (w_cmd != cmd_q) begin
            step_o  = 1'b1;
            cmd_d   = w_cmd;
            tmr_d   = '0;
            state_d = ST_HOLD;
          end else if (state_q == ST_HOLD) begin
            if (hold_dly_i == '0) begin
              tmr_d = '0;
            end else if (w_tmr_inc == {1'b0, hold_dly_i}) begin
              step_o  = 1'b1;
              tmr_d   = '0;
              state_d = ST_REPEAT;
            end else begin
              tmr_d = w_tmr_inc[DLY_W-1:0];
            end
          end else begin
            if (w_tmr_inc == {1'b0, w_rep_eff}) begin
              step_o = 1'b1;
              tmr_d  = '0;
            end else begin
              tmr_d = w_tmr_inc[DLY_W-1:0];
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cmd_d   = CMD_NONE;
          tmr_d   = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cnt_step_rpt.sv
// ---------------------------------------------------------------------------
// cnt_step_rpt : bounded up/down settings counter with saturate/wrap and auto-repeat
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cnt_step_rpt
  import cnt_step_rpt_pkg::*;
#(
  parameter int W      = 8,
  parameter int STEP_S = 1,
  parameter int STEP_L = 10,
  parameter int DLY_W  = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  cnt_step_rpt_if.slave  bus_io
);

  localparam int SW = W + 2;

  logic [W-1:0]         cnt_q, cnt_d;
  logic                 chg_q, chg_d;
  logic                 sat_q, sat_d;

  logic                 w_step;
  cmd_e                 w_cmd;
  logic                 w_misconfig;
  logic signed [SW-1:0] w_cnt_x;
  logic signed [SW-1:0] w_lbnd_x;
  logic signed [SW-1:0] w_ubnd_x;
  logic signed [SW-1:0] w_mag;
  logic signed [SW-1:0] w_sum;
  logic                 w_over;
  logic                 w_under;

  assign w_misconfig = bus_io.lbnd > bus_io.ubnd;

  cnt_step_rpt_timer #(
    .DLY_W (DLY_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold_idle_i (bus_io.clr | w_misconfig),
    .inc_s_i     (bus_io.inc_s),
    .inc_l_i     (bus_io.inc_l),
    .dec_s_i     (bus_io.dec_s),
    .dec_l_i     (bus_io.dec_l),
    .hold_dly_i  (bus_io.hold_dly),
    .rep_per_i   (bus_io.rep_per),
    .step_o      (w_step),
    .cmd_o       (w_cmd)
  );

  // Two guard bits keep both underflow below zero and overflow past 2^W visible
  assign w_cnt_x  = signed'({2'b00, cnt_q});
  assign w_lbnd_x = signed'({2'b00, bus_io.lbnd});
  assign w_ubnd_x = signed'({2'b00, bus_io.ubnd});
  assign w_mag    = cmd_is_small(w_cmd) ? SW'(STEP_S) : SW'(STEP_L);
  assign w_sum    = cmd_is_inc(w_cmd) ? (w_cnt_x + w_mag) : (w_cnt_x - w_mag);
  assign w_over   = w_sum > w_ubnd_x;
  assign w_under  = w_sum < w_lbnd_x;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = 1'b0;
    if (bus_io.clr) begin
      cnt_d = bus_io.lbnd;
    end else if (w_misconfig) begin
      cnt_d = bus_io.lbnd;
    end else if (cnt_q > bus_io.ubnd) begin
      cnt_d = bus_io.ubnd;
    end else if (cnt_q < bus_io.lbnd) begin
      cnt_d = bus_io.lbnd;
    end else if (w_step) begin
      if (w_over) begin
        sat_d = 1'b1;
        cnt_d = bus_io.mode_wrap ? bus_io.lbnd : bus_io.ubnd;
      end else if (w_under) begin
        sat_d = 1'b1;
        cnt_d = bus_io.mode_wrap ? bus_io.ubnd : bus_io.lbnd;
      end else begin
        cnt_d = w_sum[W-1:0];
      end
    end
    chg_d = cnt_d != cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      chg_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      chg_q <= chg_d;
      sat_q <= sat_d;
    end
  end

  assign bus_io.cnt     = cnt_q;
  assign bus_io.chg     = chg_q;
  assign bus_io.sat     = sat_q;
  assign bus_io.at_lbnd = cnt_q == bus_io.lbnd;
  assign bus_io.at_ubnd = cnt_q == bus_io.ubnd;

endmodule

`default_nettype wire

// File: tb/tb_cnt_step_rpt.sv
// ---------------------------------------------------------------------------
// tb_cnt_step_rpt : directed self-checking bench for cnt_step_rpt
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cnt_step_rpt;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  cnt_step_rpt_if #(.W(8), .DLY_W(16)) bus ();

  cnt_step_rpt #(
    .W      (8),
    .STEP_S (1),
    .STEP_L (10),
    .DLY_W  (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp4 [12];
    int chg_cnt;
    exp4 = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
    n_vec = 0;
    n_err = 0;

    rst_n         = 1'b0;
    bus.clr       = 1'b1;
    bus.lbnd      = 8'd5;
    bus.ubnd      = 8'd99;
    bus.mode_wrap = 1'b0;
    bus.hold_dly  = 16'd0;
    bus.rep_per   = 16'd1;
    bus.inc_s     = 1'b0;
    bus.inc_l     = 1'b0;
    bus.dec_s     = 1'b0;
    bus.dec_l     = 1'b0;

    // Reset state, then CLR loads the lower bound
    tick();
    tick();
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_at_lbnd", bus.at_lbnd, 0);
    chk("rst_chg", bus.chg, 0);
    chk("rst_sat", bus.sat, 0);
    rst_n = 1'b1;
    tick();
    chk("clr_cnt", bus.cnt, 5);
    chk("clr_chg", bus.chg, 1);
    chk("clr_at_lbnd", bus.at_lbnd, 1);
    bus.clr = 1'b0;
    tick();
    chk("clr_chg_drop", bus.chg, 0);

    // Saturate at the upper bound
    bus.lbnd = 8'd95;
    tick();
    chk("sat_load95", bus.cnt, 95);
    bus.lbnd  = 8'd0;
    bus.inc_l = 1'b1;
    tick();
    chk("sat_incl_cnt", bus.cnt, 99);
    chk("sat_incl_sat", bus.sat, 1);
    chk("sat_incl_atub", bus.at_ubnd, 1);
    bus.inc_l = 1'b0;
    tick();
    chk("sat_release_sat", bus.sat, 0);
    bus.inc_s = 1'b1;
    tick();
    chk("sat_incs_cnt", bus.cnt, 99);
    chk("sat_incs_chg", bus.chg, 0);
    chk("sat_incs_sat", bus.sat, 1);
    bus.inc_s = 1'b0;
    tick();

    // Wrap to the opposite bound
    bus.lbnd = 8'd2;
    bus.ubnd = 8'd2;
    tick();
    chk("wrap_load2", bus.cnt, 2);
    bus.lbnd      = 8'd0;
    bus.ubnd      = 8'd59;
    bus.mode_wrap = 1'b1;
    bus.dec_l     = 1'b1;
    tick();
    chk("wrap_decl_cnt", bus.cnt, 59);
    chk("wrap_decl_sat", bus.sat, 1);
    bus.dec_l = 1'b0;
    tick();
    bus.inc_s = 1'b1;
    tick();
    chk("wrap_incs_cnt", bus.cnt, 0);
    chk("wrap_incs_sat", bus.sat, 1);
    bus.inc_s = 1'b0;
    tick();

    // Auto-repeat: first step, hold delay 4, period 2
    bus.mode_wrap = 1'b0;
    bus.ubnd      = 8'd99;
    bus.hold_dly  = 16'd4;
    bus.rep_per   = 16'd2;
    bus.inc_s     = 1'b1;
    chg_cnt       = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (bus.chg) chg_cnt++;
      chk($sformatf("rpt_cnt_e%0d", j), bus.cnt, exp4[j]);
    end
    chk("rpt_chg_pulses", chg_cnt, 5);
    bus.inc_s = 1'b0;
    tick();
    chk("rpt_release_cnt", bus.cnt, 5);
    chk("rpt_release_chg", bus.chg, 0);

    // Command switch while held; INC_S wins over DEC_L when both pressed
    bus.lbnd     = 8'd30;
    bus.ubnd     = 8'd30;
    bus.hold_dly = 16'd8;
    tick();
    chk("sw_load30", bus.cnt, 30);
    bus.lbnd  = 8'd0;
    bus.ubnd  = 8'd99;
    bus.inc_s = 1'b1;
    bus.dec_l = 1'b1;
    tick();
    chk("sw_prio_cnt", bus.cnt, 31);
    tick();
    chk("sw_hold_cnt", bus.cnt, 31);
    bus.inc_s = 1'b0;
    tick();
    chk("sw_switch_cnt", bus.cnt, 21);
    chk("sw_switch_chg", bus.chg, 1);
    for (int j = 0; j < 7; j++) begin
      tick();
      chk($sformatf("sw_wait_e%0d", j), bus.cnt, 21);
    end
    tick();
    chk("sw_repeat_cnt", bus.cnt, 11);
    bus.dec_l = 1'b0;
    tick();

    // Bound change forces CNT, discarding the concurrent step; then misconfig
    bus.lbnd = 8'd50;
    tick();
    chk("bf_load50", bus.cnt, 50);
    bus.lbnd  = 8'd0;
    bus.ubnd  = 8'd30;
    bus.inc_s = 1'b1;
    tick();
    chk("bf_cnt", bus.cnt, 30);
    chk("bf_chg", bus.chg, 1);
    chk("bf_sat", bus.sat, 0);
    bus.inc_s = 1'b0;
    tick();
    chk("bf_release_cnt", bus.cnt, 30);
    bus.lbnd = 8'd40;
    tick();
    chk("mis_cnt", bus.cnt, 40);
    chk("mis_chg", bus.chg, 1);
    bus.inc_s = 1'b1;
    tick();
    chk("mis_inc_cnt", bus.cnt, 40);
    chk("mis_inc_chg", bus.chg, 0);
    chk("mis_inc_sat", bus.sat, 0);
    tick();
    chk("mis_inc2_cnt", bus.cnt, 40);
    chk("mis_at_lbnd", bus.at_lbnd, 1);
    bus.inc_s = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
